pipe_dec_stage: RTL and testbench

//  Parametrised IF->ID pipeline register for the MIPS core. Carries PC, fetch exception code, delay-slot flag and valid bit.

---
 rtl/pipe_dec_stage.sv | 97 +++++++++
 tb/tb_pipe_dec_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_dec_stage.sv
// IF->ID pipeline register: PC/exception/delay-slot/valid plus late-arriving instruction capture.
// Optional STAGE_PERF_EN macro adds saturating stall/bubble counters (stall_cnt, bubble_cnt).
module pipe_dec_stage #(
  parameter int unsigned     INSTR_W        = 32,
  parameter int unsigned     PC_W           = 32,
  parameter int unsigned     EXC_W          = 5,
  parameter logic [PC_W-1:0] RESET_PC       = 32'h0000_3000,
  parameter logic [PC_W-1:0] HANDLER_PC     = 32'h0000_4180,
  parameter bit              FLUSH_KEEP_EXC = 1'b1
`ifdef STAGE_PERF_EN
  , parameter int unsigned   CNT_W          = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               req,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [EXC_W-1:0]   exc_in,
  input  logic               slot_in,
  input  logic               valid_in,
  input  logic [PC_W-1:0]    jumpto,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [EXC_W-1:0]   exc_out,
  output logic               slot_out,
  output logic               valid_out
`ifdef STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  logic               pass;
  logic [INSTR_W-1:0] hold;
  logic [INSTR_W-1:0] instr_raw;

  // The IM answers one cycle late: use it live right after an advance, else the captured copy.
  always_comb begin
    instr_raw = pass ? instr_in : hold;
    instr_out = instr_raw;
    if (exc_out != '0 || !valid_out) instr_out = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass      <= 1'b0;
      hold      <= '0;
      pc_out    <= RESET_PC;
      exc_out   <= '0;
      slot_out  <= 1'b0;
      valid_out <= 1'b0;
    end else if (req) begin
      pass      <= 1'b0;
      hold      <= '0;
      pc_out    <= HANDLER_PC;
      exc_out   <= '0;
      slot_out  <= 1'b0;
      valid_out <= 1'b0;
    end else if (stall) begin
      pass      <= 1'b0;
      hold      <= instr_raw;
    end else if (flush) begin
      pass      <= 1'b0;
      hold      <= '0;
      pc_out    <= jumpto;
      exc_out   <= FLUSH_KEEP_EXC ? exc_in : '0;
      slot_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      pass      <= 1'b1;
      hold      <= instr_in;
      pc_out    <= pc_in;
      exc_out   <= exc_in;
      slot_out  <= slot_in;
      valid_out <= valid_in;
    end
  end

`ifdef STAGE_PERF_EN
  // A stall under req is overridden, so it is not counted; flush under stall is deferred, not a bubble yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && !req && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if ((req || (flush && !stall)) && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_dec_stage.sv
// Directed bench for pipe_dec_stage (FLUSH_KEEP_EXC=0; CNT_W=2 when STAGE_PERF_EN is defined).
module tb_pipe_dec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, req, flush, slot_in, valid_in;
  logic [31:0] instr_in, pc_in, jumpto;
  logic [4:0]  exc_in;
  logic [31:0] instr_out, pc_out;
  logic [4:0]  exc_out;
  logic        slot_out, valid_out;
`ifdef STAGE_PERF_EN
  logic [1:0]  stall_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_dec_stage #(
    .INSTR_W(32), .PC_W(32), .EXC_W(5),
    .RESET_PC(32'h0000_3000), .HANDLER_PC(32'h0000_4180),
    .FLUSH_KEEP_EXC(1'b0)
`ifdef STAGE_PERF_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req(req), .flush(flush),
    .instr_in(instr_in), .pc_in(pc_in), .exc_in(exc_in), .slot_in(slot_in),
    .valid_in(valid_in), .jumpto(jumpto),
    .instr_out(instr_out), .pc_out(pc_out), .exc_out(exc_out),
    .slot_out(slot_out), .valid_out(valid_out)
`ifdef STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; req = 1'b0; flush = 1'b0;
    instr_in = 32'hDEAD_BEEF; pc_in = 32'h0; exc_in = 5'd0;
    slot_in = 1'b0; valid_in = 1'b0; jumpto = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc_out, 32'h0000_3000);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_exc", {27'b0, exc_out}, 32'h0);
`ifdef STAGE_PERF_EN
    chk("rst_stall_cnt", {30'b0, stall_cnt}, 32'h0);
`endif
    step();
    rst_n = 1'b1;

    // Advance: PC registered, IM data appears live the following cycle
    pc_in = 32'h0000_3004; instr_in = 32'h2408_0005; valid_in = 1'b1; slot_in = 1'b1;
    step();
    chk("adv_pc", pc_out, 32'h0000_3004);
    chk("adv_instr", instr_out, 32'h2408_0005);
    chk("adv_valid", {31'b0, valid_out}, 32'h1);
    chk("adv_slot", {31'b0, slot_out}, 32'h1);

    // Stall 3 cycles; IM data changes after the first stall edge; flush during stall is ignored
    stall = 1'b1; pc_in = 32'h0000_3008; slot_in = 1'b0;
    step();
    instr_in = 32'hFFFF_FFFF;
    #1;
    chk("stall1_instr", instr_out, 32'h2408_0005);
    chk("stall1_pc", pc_out, 32'h0000_3004);
    flush = 1'b1; jumpto = 32'h0000_3500;
    step();
    chk("stall2_instr", instr_out, 32'h2408_0005);
    chk("stall_flush_pc", pc_out, 32'h0000_3004);
    flush = 1'b0;
    step();
    chk("stall3_instr", instr_out, 32'h2408_0005);
    chk("stall3_pc", pc_out, 32'h0000_3004);
    chk("stall3_valid", {31'b0, valid_out}, 32'h1);
`ifdef STAGE_PERF_EN
    chk("stall3_stall_cnt", {30'b0, stall_cnt}, 32'h3);
    chk("stall3_bubble_cnt", {30'b0, bubble_cnt}, 32'h0);
`endif

    // Flush with exception code present, FLUSH_KEEP_EXC=0
    stall = 1'b0; flush = 1'b1; jumpto = 32'h0000_3100; exc_in = 5'd4; valid_in = 1'b1;
    step();
    chk("flush_pc", pc_out, 32'h0000_3100);
    chk("flush_exc", {27'b0, exc_out}, 32'h0);
    chk("flush_instr", instr_out, 32'h0);
    chk("flush_valid", {31'b0, valid_out}, 32'h0);
`ifdef STAGE_PERF_EN
    chk("flush_bubble_cnt", {30'b0, bubble_cnt}, 32'h1);
`endif

    // Advance a faulting slot, then reset mid-cycle
    flush = 1'b0; pc_in = 32'h0000_3300; exc_in = 5'd2; slot_in = 1'b1; instr_in = 32'hAAAA_5555;
    step();
    chk("fault_exc", {27'b0, exc_out}, 32'h2);
    chk("fault_slot", {31'b0, slot_out}, 32'h1);
    chk("fault_instr", instr_out, 32'h0);
    #2 rst_n = 1'b0; stall = 1'b1; flush = 1'b1; req = 1'b1;
    #1;
    chk("midrst_pc", pc_out, 32'h0000_3000);
    chk("midrst_instr", instr_out, 32'h0);
    chk("midrst_valid", {31'b0, valid_out}, 32'h0);
    chk("midrst_exc", {27'b0, exc_out}, 32'h0);
    chk("midrst_slot", {31'b0, slot_out}, 32'h0);
`ifdef STAGE_PERF_EN
    chk("midrst_stall_cnt", {30'b0, stall_cnt}, 32'h0);
    chk("midrst_bubble_cnt", {30'b0, bubble_cnt}, 32'h0);
`endif
    step();
    chk("rst_held_pc", pc_out, 32'h0000_3000);
    rst_n = 1'b1;

    // req with stall and flush: req wins
    step();
    chk("req_pc", pc_out, 32'h0000_4180);
    chk("req_valid", {31'b0, valid_out}, 32'h0);
    chk("req_slot", {31'b0, slot_out}, 32'h0);
    chk("req_exc", {27'b0, exc_out}, 32'h0);
`ifdef STAGE_PERF_EN
    chk("req_stall_cnt", {30'b0, stall_cnt}, 32'h0);
    chk("req_bubble_cnt", {30'b0, bubble_cnt}, 32'h1);
`endif

    // AdEL fetch fault squashes instruction to NOP
    req = 1'b0; stall = 1'b0; flush = 1'b0;
    pc_in = 32'h0000_3200; exc_in = 5'd4; instr_in = 32'h1234_5678; valid_in = 1'b1; slot_in = 1'b0;
    step();
    chk("adel_exc", {27'b0, exc_out}, 32'h4);
    chk("adel_instr", instr_out, 32'h0);
    chk("adel_pc", pc_out, 32'h0000_3200);

    // Long stall: counter saturates at 3 with CNT_W=2
    stall = 1'b1; pc_in = 32'h0000_3ABC;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("lstall_pc", pc_out, 32'h0000_3200);
`ifdef STAGE_PERF_EN
      chk("lstall_stall_cnt", {30'b0, stall_cnt}, (i > 3) ? 32'h3 : i);
`endif
    end
    chk("lstall_exc", {27'b0, exc_out}, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
